regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_write_arbiter_wb_fifo.sv | 49 ++++
 rtl/regfile_write_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, source ids and sequence-age helper for the writeback arbiter
package regfile_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int SEQ_W  = 3;

    typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

    // a is older than b when the wrapped difference a - b is negative
    function automatic logic seq_older(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
        logic [SEQ_W-1:0] d;
        d = a - b;
        return d[SEQ_W-1];
    endfunction
endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// wb_fifo: shift-register writeback queue; slot 0 is always the head, so no read pointer
module wb_fifo #(
    parameter int W     = 40,
    parameter int AW    = 5,
    parameter int A_LSB = 32,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             head_o,
    output logic [DEPTH-1:0][AW-1:0] rw_o,
    output logic [DEPTH-1:0]         vld_o,
    output logic [CW-1:0]            cnt_o
);
    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [CW-1:0] cnt_q, cnt_d, wr_idx;

    always_comb begin
        rw_o = '0;
        vld_o = '0;
        wr_idx = cnt_q - CW'(pop_i);
        cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
        mem_d = mem_q;
        for (int k = 0; k < DEPTH - 1; k++)
            if (pop_i) mem_d[k] = mem_q[k+1];
        for (int k = 0; k < DEPTH; k++) begin
            if (push_i && wr_idx == CW'(k)) mem_d[k] = din_i;
            rw_o[k] = mem_q[k][A_LSB +: AW];
            vld_o[k] = CW'(k) < cnt_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o = mem_q[0];
    assign cnt_o  = cnt_q;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges ALU and load writebacks onto the single register-file write port,
// keeping per-source order and letting the older of two writes to the same register land first.
module regfile_write_arbiter #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rw,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rw,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] BusW,
    output logic              sig_enable_write,
    output logic [31:0]       pending,
    output logic              busy
);
    import regfile_pkg::*;

    localparam int EW = SEQ_W + ADDR_W + DATA_W;
    localparam int CW = $clog2(DEPTH + 1);

    logic [EW-1:0] a_head, m_head;
    logic [DEPTH-1:0][ADDR_W-1:0] a_tag, m_tag;
    logic [DEPTH-1:0] a_vld, m_vld;
    logic [CW-1:0] a_cnt, m_cnt;
    logic [SEQ_W-1:0] a_seq, m_seq, seq_q, seq_d;
    logic [ADDR_W-1:0] a_rw, m_rw, rw_q, rw_d;
    logic [DATA_W-1:0] a_data, m_data, bus_q, bus_d;
    logic a_push, m_push, a_pop, m_pop, we_q, we_d;
    src_e pick, last_q, last_d;

    assign alu_ready = a_cnt < CW'(DEPTH);
    assign mem_ready = m_cnt < CW'(DEPTH);
    // R0 writes are acknowledged but never enter a queue
    assign a_push = alu_valid && alu_ready && alu_rw != '0;
    assign m_push = mem_valid && mem_ready && mem_rw != '0;
    assign {a_seq, a_rw, a_data} = a_head;
    assign {m_seq, m_rw, m_data} = m_head;

    // on a simultaneous accept the MEM entry takes the lower sequence number
    wb_fifo #(.W(EW), .AW(ADDR_W), .A_LSB(DATA_W), .DEPTH(DEPTH)) u_alu_q (
        .clk_i(clock), .rst_i(reset), .push_i(a_push), .pop_i(a_pop),
        .din_i({seq_q + SEQ_W'(m_push), alu_rw, alu_data}),
        .head_o(a_head), .rw_o(a_tag), .vld_o(a_vld), .cnt_o(a_cnt)
    );

    wb_fifo #(.W(EW), .AW(ADDR_W), .A_LSB(DATA_W), .DEPTH(DEPTH)) u_mem_q (
        .clk_i(clock), .rst_i(reset), .push_i(m_push), .pop_i(m_pop),
        .din_i({seq_q, mem_rw, mem_data}),
        .head_o(m_head), .rw_o(m_tag), .vld_o(m_vld), .cnt_o(m_cnt)
    );

    always_comb begin
        pick = (a_vld[0] && m_vld[0])
             ? ((a_rw == m_rw) ? (seq_older(m_seq, a_seq) ? SRC_MEM : SRC_ALU)
                               : ((last_q == SRC_MEM) ? SRC_ALU : SRC_MEM))
             : (m_vld[0] ? SRC_MEM : SRC_ALU);
        we_d = a_vld[0] || m_vld[0];
        a_pop = we_d && pick == SRC_ALU;
        m_pop = we_d && pick == SRC_MEM;
        rw_d = a_pop ? a_rw : (m_pop ? m_rw : '0);
        bus_d = a_pop ? a_data : (m_pop ? m_data : '0);
        last_d = we_d ? pick : last_q;
        seq_d = seq_q + SEQ_W'(a_push) + SEQ_W'(m_push);
    end

    always_comb begin
        pending = we_q ? 32'(1) << rw_q : '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (a_vld[k]) pending = pending | 32'(1) << a_tag[k];
            if (m_vld[k]) pending = pending | 32'(1) << m_tag[k];
        end
        pending[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seq_q  <= '0;
            last_q <= SRC_MEM;
            we_q   <= 1'b0;
            rw_q   <= '0;
            bus_q  <= '0;
        end else begin
            seq_q  <= seq_d;
            last_q <= last_d;
            we_q   <= we_d;
            rw_q   <= rw_d;
            bus_q  <= bus_d;
        end
    end

    assign RW               = rw_q;
    assign BusW             = bus_q;
    assign sig_enable_write = we_q;
    assign busy             = a_vld[0] || m_vld[0] || we_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vectors with a queue-level reference model compared every cycle,
// plus hand-computed expectations for the key scenarios.
module tb_regfile_write_arbiter;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic alu_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0] alu_rw = '0, mem_rw = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic alu_ready, mem_ready, sig_enable_write, busy;
    logic [4:0] RW;
    logic [31:0] BusW, pending;

    int n_vec = 0;
    int n_bad = 0;

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
        .clock(clk), .reset(rst),
        .alu_valid(alu_valid), .alu_rw(alu_rw), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_data(mem_data), .mem_ready(mem_ready),
        .RW(RW), .BusW(BusW), .sig_enable_write(sig_enable_write),
        .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    // reference model: two bounded queues, unbounded age counter, last-granted source
    typedef struct { logic [4:0] rw; logic [31:0] data; int seq; } ent_t;
    ent_t aq[$];
    ent_t mq[$];
    int seqn = 0;
    int m_last = 1;
    logic ov = 1'b0;
    logic [4:0] orw = '0;
    logic [31:0] odata = '0;

    task automatic model_edge();
        int g;
        bit a_acc, m_acc;
        g = -1;
        if (aq.size() > 0 && mq.size() > 0)
            g = (aq[0].rw == mq[0].rw) ? ((aq[0].seq < mq[0].seq) ? 0 : 1) : ((m_last == 1) ? 0 : 1);
        else if (aq.size() > 0) g = 0;
        else if (mq.size() > 0) g = 1;
        a_acc = alu_valid && aq.size() < DEPTH && alu_rw != 0;
        m_acc = mem_valid && mq.size() < DEPTH && mem_rw != 0;
        ov = g >= 0;
        orw = (g == 0) ? aq[0].rw : ((g == 1) ? mq[0].rw : 5'd0);
        odata = (g == 0) ? aq[0].data : ((g == 1) ? mq[0].data : 32'd0);
        if (g >= 0) m_last = g;
        if (g == 0) void'(aq.pop_front());
        if (g == 1) void'(mq.pop_front());
        if (m_acc) begin mq.push_back('{mem_rw, mem_data, seqn}); seqn++; end
        if (a_acc) begin aq.push_back('{alu_rw, alu_data, seqn}); seqn++; end
    endtask

    function automatic logic [31:0] exp_pending();
        logic [31:0] p;
        p = ov ? (32'd1 << orw) : 32'd0;
        foreach (aq[i]) p[aq[i].rw] = 1'b1;
        foreach (mq[i]) p[mq[i].rw] = 1'b1;
        return p;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aq.delete(); mq.delete();
            seqn = 0; m_last = 1; ov = 1'b0; orw = '0; odata = '0;
        end else model_edge();
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_we", sig_enable_write, ov);
        chk("cmp_rw", RW, orw);
        chk("cmp_busw", BusW, odata);
        chk("cmp_pending", pending, exp_pending());
        chk("cmp_busy", busy, aq.size() > 0 || mq.size() > 0 || ov);
        chk("cmp_alu_ready", alu_ready, aq.size() < DEPTH);
        chk("cmp_mem_ready", mem_ready, mq.size() < DEPTH);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        alu_valid = 1'b0; mem_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        repeat (2) step();
        chk("rst_we", sig_enable_write, 1'b0);
        chk("rst_rw", RW, 5'd0);
        chk("rst_busw", BusW, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", {alu_ready, mem_ready}, 2'b11);
        rst = 1'b0;
        step();

        // single ALU write
        alu_valid = 1'b1; alu_rw = 5'd3; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 1'b0;
        chk("t1_queued_we", sig_enable_write, 1'b0);
        chk("t1_queued_pending", pending, 32'h8);
        step();
        chk("t1_we", sig_enable_write, 1'b1);
        chk("t1_rw", RW, 5'd3);
        chk("t1_busw", BusW, 32'hDEADBEEF);
        chk("t1_issue_pending", pending, 32'h8);
        step();
        chk("t1_we_drop", sig_enable_write, 1'b0);
        chk("t1_pending_clear", pending, 32'h0);
        chk("t1_idle_busw", BusW, 32'h0);

        // same register from both sources: MEM is older
        alu_valid = 1'b1; alu_rw = 5'd5; alu_data = 32'hA5A5_0001;
        mem_valid = 1'b1; mem_rw = 5'd5; mem_data = 32'h0000_5555;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        step();
        chk("t2_first_rw", RW, 5'd5);
        chk("t2_first_mem", BusW, 32'h0000_5555);
        step();
        chk("t2_second_alu", BusW, 32'hA5A5_0001);
        step();
        chk("t2_idle_we", sig_enable_write, 1'b0);

        // fresh reset so the first tie goes to the ALU, then stream both sources
        rst = 1'b1;
        step();
        rst = 1'b0;
        alu_valid = 1'b1; alu_rw = 5'd10;
        mem_valid = 1'b1; mem_rw = 5'd20;
        for (int k = 0; k < 9; k++) begin
            alu_data = 32'h1000 + k;
            mem_data = 32'h2000 + k;
            step();
            if (k > 0) begin
                chk("t3_we", sig_enable_write, 1'b1);
                chk("t3_alternate_rw", RW, (k % 2 == 1) ? 5'd10 : 5'd20);
            end
            if (k == 1) chk("t3_first_alu", BusW, 32'h1000);
            if (k == 2) chk("t3_first_mem", BusW, 32'h2000);
        end
        idle(6);

        // older MEM writes to r7 hold the ALU queue until it fills
        mem_valid = 1'b1; mem_rw = 5'd7; mem_data = 32'h0A01;
        step();
        mem_data = 32'h0A02;
        alu_valid = 1'b1; alu_rw = 5'd7; alu_data = 32'h0B01;
        step();
        chk("t4_m1", BusW, 32'h0A01);
        mem_data = 32'h0A03; alu_data = 32'h0B02;
        step();
        chk("t4_m2", BusW, 32'h0A02);
        chk("t4_alu_full", alu_ready, 1'b0);
        mem_valid = 1'b0; alu_data = 32'h0B03;
        step();
        chk("t4_a1", BusW, 32'h0B01);
        chk("t4_alu_free", alu_ready, 1'b1);
        step();
        chk("t4_m3", BusW, 32'h0A03);
        alu_valid = 1'b0;
        step();
        chk("t4_a2", BusW, 32'h0B02);
        step();
        chk("t4_a3", BusW, 32'h0B03);
        step();
        chk("t4_idle_we", sig_enable_write, 1'b0);

        // write to R0 is accepted and dropped
        alu_valid = 1'b1; alu_rw = 5'd0; alu_data = 32'hFFFF_FFFF;
        chk("t5_ready", alu_ready, 1'b1);
        step();
        alu_valid = 1'b0;
        chk("t5_pending", pending, 32'h0);
        chk("t5_busy", busy, 1'b0);
        step();
        chk("t5_we_a", sig_enable_write, 1'b0);
        step();
        chk("t5_we_b", sig_enable_write, 1'b0);

        // reset mid-operation with two entries queued and one issuing
        alu_valid = 1'b1; alu_rw = 5'd12; alu_data = 32'hC12;
        mem_valid = 1'b1; mem_rw = 5'd13; mem_data = 32'hC13;
        step();
        mem_valid = 1'b0; alu_rw = 5'd14; alu_data = 32'hC14;
        step();
        alu_valid = 1'b0;
        chk("t6_pre_rw", RW, 5'd13);
        chk("t6_pre_pending", pending, 32'h0000_7000);
        #1 rst = 1'b1;
        #1;
        chk("t6_async_we", sig_enable_write, 1'b0);
        chk("t6_rst_pending", pending, 32'h0);
        chk("t6_rst_busy", busy, 1'b0);
        step();
        rst = 1'b0;
        chk("t6_ready_after", {alu_ready, mem_ready}, 2'b11);
        step();
        chk("t6_no_write", sig_enable_write, 1'b0);
        chk("t6_busy", busy, 1'b0);
        step();
        chk("t6_no_write2", sig_enable_write, 1'b0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
